// File: rtl/instr_fetch_mem_if.sv
// Fetch-side bus for instr_fetch_mem: request/response handshakes, flush and program-load port.
// master = IF-stage/PC side, slave = instruction memory.
interface instr_fetch_mem_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic                  resp_valid;
    logic                  resp_ready;
    logic [DATA_WIDTH-1:0] resp_instr;
    logic [ADDR_WIDTH-1:0] resp_addr;
    logic                  resp_fault;
    logic                  flush;
    logic                  load_en;
    logic [ADDR_WIDTH-1:0] load_addr;
    logic [DATA_WIDTH-1:0] load_data;

    modport master (
        output req_valid, req_addr, resp_ready, flush, load_en, load_addr, load_data,
        input  req_ready, resp_valid, resp_instr, resp_addr, resp_fault
    );

    modport slave (
        input  req_valid, req_addr, resp_ready, flush, load_en, load_addr, load_data,
        output req_ready, resp_valid, resp_instr, resp_addr, resp_fault
    );
endinterface

// File: rtl/instr_fetch_mem.sv
// Pipelined instruction memory: fixed-latency reads, in-order responses through an output FIFO,
// credit-based request throttling, flush, fault reporting and a word-write load port.
module instr_fetch_mem #(
    parameter int unsigned     DATA_WIDTH   = 32,
    parameter int unsigned     ADDR_WIDTH   = 32,
    parameter int unsigned     DEPTH_WORDS  = 1024,
    parameter int unsigned     READ_LATENCY = 1,
    parameter logic [DATA_WIDTH-1:0] NOP_WORD = 32'h0000_0013
) (
    input logic              clk_i,
    input logic              rst_i,
    instr_fetch_mem_if.slave fetch_if
);
    localparam int unsigned IdxW = $clog2(DEPTH_WORDS);

    typedef logic [DATA_WIDTH-1:0] mem_t [DEPTH_WORDS];

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] instr;
        logic                  fault;
    } entry_t;

    function automatic mem_t init_mem();
        mem_t m;
        for (int i = 0; i < int'(DEPTH_WORDS); i++) begin
            case (i)
                0:       m[i] = DATA_WIDTH'(32'h0000_0013);
                1:       m[i] = DATA_WIDTH'(32'h0000_0093);
                2:       m[i] = DATA_WIDTH'(32'h0010_0113);
                3:       m[i] = DATA_WIDTH'(32'h0020_81B3);
                4:       m[i] = DATA_WIDTH'(32'h0031_0133);
                5:       m[i] = DATA_WIDTH'(32'h4041_A183);
                default: m[i] = NOP_WORD;
            endcase
        end
        return m;
    endfunction

    // Program image is a power-up value only; reset never touches the array.
    mem_t mem_q = init_mem();

    logic [IdxW-1:0] req_idx, load_idx;
    logic            req_fault, load_ok;
    logic            req_ready, accept, pop, resp_valid;
    logic [2:0]      out_q, out_d, cnt_q, cnt_d;
    entry_t          acc_e, push_e;
    logic            push_v;
    entry_t          fifo_q [READ_LATENCY];
    entry_t          fifo_d [READ_LATENCY];

    assign req_idx   = fetch_if.req_addr[IdxW+1:2];
    assign req_fault = (|fetch_if.req_addr[1:0]) || (|fetch_if.req_addr[ADDR_WIDTH-1:IdxW+2]);
    assign load_idx  = fetch_if.load_addr[IdxW+1:2];
    assign load_ok   = fetch_if.load_en && !(|fetch_if.load_addr[1:0])
                       && !(|fetch_if.load_addr[ADDR_WIDTH-1:IdxW+2]);

    assign resp_valid = (cnt_q != 3'd0);
    assign pop        = resp_valid && fetch_if.resp_ready;
    assign req_ready  = !fetch_if.flush && ((out_q < 3'(READ_LATENCY)) || pop);
    assign accept     = fetch_if.req_valid && req_ready;

    // Read happens at the accept edge, so a same-edge load write is not yet visible.
    assign acc_e.addr  = fetch_if.req_addr;
    assign acc_e.instr = req_fault ? NOP_WORD : mem_q[req_idx];
    assign acc_e.fault = req_fault;

    always_ff @(posedge clk_i) begin
        if (load_ok) begin
            mem_q[load_idx] <= fetch_if.load_data;
        end
    end

    if (READ_LATENCY > 1) begin : g_pipe
        localparam int unsigned Stages = READ_LATENCY - 1;
        logic [Stages-1:0] v_q;
        entry_t            e_q [Stages];

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                v_q <= '0;
            end else if (fetch_if.flush) begin
                v_q <= '0;
            end else begin
                for (int i = int'(Stages) - 1; i > 0; i--) begin
                    v_q[i] <= v_q[i-1];
                end
                v_q[0] <= accept;
            end
        end

        always_ff @(posedge clk_i) begin
            for (int i = int'(Stages) - 1; i > 0; i--) begin
                e_q[i] <= e_q[i-1];
            end
            e_q[0] <= acc_e;
        end

        assign push_v = v_q[Stages-1];
        assign push_e = e_q[Stages-1];
    end else begin : g_direct
        assign push_v = accept;
        assign push_e = acc_e;
    end

    // Shift-down FIFO: head always at index 0, push lands after the surviving entries.
    always_comb begin
        fifo_d = fifo_q;
        cnt_d  = cnt_q;
        out_d  = out_q;
        if (fetch_if.flush) begin
            cnt_d = '0;
            out_d = '0;
        end else begin
            if (pop) begin
                for (int i = 0; i < int'(READ_LATENCY) - 1; i++) begin
                    fifo_d[i] = fifo_q[i+1];
                end
            end
            for (int i = 0; i < int'(READ_LATENCY); i++) begin
                if (push_v && (i == int'(cnt_q) - int'(pop))) begin
                    fifo_d[i] = push_e;
                end
            end
            cnt_d = cnt_q + 3'(push_v) - 3'(pop);
            out_d = out_q + 3'(accept) - 3'(pop);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q  <= '0;
            out_q  <= '0;
            fifo_q <= '{default: '0};
        end else begin
            cnt_q  <= cnt_d;
            out_q  <= out_d;
            fifo_q <= fifo_d;
        end
    end

    assign fetch_if.req_ready  = req_ready;
    assign fetch_if.resp_valid = resp_valid;
    assign fetch_if.resp_instr = fifo_q[0].instr;
    assign fetch_if.resp_addr  = fifo_q[0].addr;
    assign fetch_if.resp_fault = fifo_q[0].fault;
endmodule

// File: tb/tb_instr_fetch_mem.sv
// Directed bench for instr_fetch_mem: three instances at READ_LATENCY 1, 2 and 3.
module tb_instr_fetch_mem;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    instr_fetch_mem_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) if1 ();
    instr_fetch_mem_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) if2 ();
    instr_fetch_mem_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) if3 ();

    instr_fetch_mem #(.READ_LATENCY(1)) u_dut1 (.clk_i(clk), .rst_i(rst), .fetch_if(if1));
    instr_fetch_mem #(.READ_LATENCY(2)) u_dut2 (.clk_i(clk), .rst_i(rst), .fetch_if(if2));
    instr_fetch_mem #(.READ_LATENCY(3)) u_dut3 (.clk_i(clk), .rst_i(rst), .fetch_if(if3));

    typedef struct {
        logic        rv;
        logic [31:0] ra;
        logic        rr;
        logic        ev;
        logic [31:0] ei;
        logic [31:0] ea;
        logic        ef;
        logic        erdy;
    } vec_t;

    vec_t vecs [16];
    int   acc;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // inputs, then expectations: valid, instr, addr, fault, req_ready
        vecs[0]  = '{1'b1, 32'h0000, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1};
        vecs[1]  = '{1'b1, 32'h0004, 1'b1, 1'b1, 32'h0000_0013, 32'h0000, 1'b0, 1'b1};
        vecs[2]  = '{1'b1, 32'h0008, 1'b1, 1'b1, 32'h0000_0093, 32'h0004, 1'b0, 1'b1};
        vecs[3]  = '{1'b1, 32'h000C, 1'b1, 1'b1, 32'h0010_0113, 32'h0008, 1'b0, 1'b1};
        vecs[4]  = '{1'b0, 32'h0000, 1'b1, 1'b1, 32'h0020_81B3, 32'h000C, 1'b0, 1'b1};
        vecs[5]  = '{1'b1, 32'h0006, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1};
        vecs[6]  = '{1'b1, 32'h1000, 1'b1, 1'b1, 32'h0000_0013, 32'h0006, 1'b1, 1'b1};
        vecs[7]  = '{1'b1, 32'h0010, 1'b1, 1'b1, 32'h0000_0013, 32'h1000, 1'b1, 1'b1};
        vecs[8]  = '{1'b1, 32'h0FFC, 1'b1, 1'b1, 32'h0031_0133, 32'h0010, 1'b0, 1'b1};
        vecs[9]  = '{1'b0, 32'h0000, 1'b1, 1'b1, 32'h0000_0013, 32'h0FFC, 1'b0, 1'b1};
        vecs[10] = '{1'b0, 32'h0000, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1};
        vecs[11] = '{1'b1, 32'h0014, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1};
        vecs[12] = '{1'b1, 32'h0004, 1'b0, 1'b1, 32'h4041_A183, 32'h0014, 1'b0, 1'b0};
        vecs[13] = '{1'b1, 32'h0004, 1'b1, 1'b1, 32'h4041_A183, 32'h0014, 1'b0, 1'b1};
        vecs[14] = '{1'b0, 32'h0000, 1'b1, 1'b1, 32'h0000_0093, 32'h0004, 1'b0, 1'b1};
        vecs[15] = '{1'b0, 32'h0000, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1};

        if1.req_valid = 1'b0; if1.req_addr = '0; if1.resp_ready = 1'b0; if1.flush = 1'b0;
        if1.load_en = 1'b0; if1.load_addr = '0; if1.load_data = '0;
        if2.req_valid = 1'b0; if2.req_addr = '0; if2.resp_ready = 1'b0; if2.flush = 1'b0;
        if2.load_en = 1'b0; if2.load_addr = '0; if2.load_data = '0;
        if3.req_valid = 1'b0; if3.req_addr = '0; if3.resp_ready = 1'b0; if3.flush = 1'b0;
        if3.load_en = 1'b0; if3.load_addr = '0; if3.load_data = '0;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check("rst_valid1", 64'(if1.resp_valid), 64'd0);
        check("rst_ready1", 64'(if1.req_ready), 64'd1);
        check("rst_instr1", 64'(if1.resp_instr), 64'd0);
        check("rst_addr1", 64'(if1.resp_addr), 64'd0);
        check("rst_fault1", 64'(if1.resp_fault), 64'd0);
        check("rst_valid2", 64'(if2.resp_valid), 64'd0);
        check("rst_ready3", 64'(if3.req_ready), 64'd1);

        // Lat-1 stream: throughput, faults in order, single-slot backpressure
        for (int r = 0; r < 16; r++) begin
            if1.req_valid  = vecs[r].rv;
            if1.req_addr   = vecs[r].ra;
            if1.resp_ready = vecs[r].rr;
            #1;
            check($sformatf("row%0d_valid", r), 64'(if1.resp_valid), 64'(vecs[r].ev));
            check($sformatf("row%0d_ready", r), 64'(if1.req_ready), 64'(vecs[r].erdy));
            if (vecs[r].ev) begin
                check($sformatf("row%0d_instr", r), 64'(if1.resp_instr), 64'(vecs[r].ei));
                check($sformatf("row%0d_addr", r), 64'(if1.resp_addr), 64'(vecs[r].ea));
                check($sformatf("row%0d_fault", r), 64'(if1.resp_fault), 64'(vecs[r].ef));
            end
            tick();
        end

        // Load port: same-edge read sees old word; bad-address writes dropped
        if1.load_en = 1'b1; if1.load_addr = 32'h8; if1.load_data = 32'hDEAD_BEEF;
        if1.req_valid = 1'b1; if1.req_addr = 32'h8; if1.resp_ready = 1'b1;
        #1;
        check("ld_ready", 64'(if1.req_ready), 64'd1);
        tick();
        if1.load_addr = 32'hA; if1.load_data = 32'h1234_5678;
        #1;
        check("ld_old_valid", 64'(if1.resp_valid), 64'd1);
        check("ld_old_instr", 64'(if1.resp_instr), 64'h0010_0113);
        tick();
        if1.load_addr = 32'h1008; if1.load_data = 32'hCAFE_F00D;
        #1;
        check("ld_new_instr", 64'(if1.resp_instr), 64'hDEAD_BEEF);
        tick();
        if1.load_en = 1'b0;
        #1;
        check("ld_misalign_ign", 64'(if1.resp_instr), 64'hDEAD_BEEF);
        tick();
        if1.req_valid = 1'b0;
        #1;
        check("ld_range_ign", 64'(if1.resp_instr), 64'hDEAD_BEEF);
        tick();
        check("ld_drain", 64'(if1.resp_valid), 64'd0);

        // Lat-3 backpressure: three credits, then consume frees a slot same cycle
        acc = 0;
        if3.resp_ready = 1'b0;
        for (int c = 0; c < 8; c++) begin
            if3.req_valid = 1'b1;
            if3.req_addr  = 32'(acc * 4);
            #1;
            if (if3.req_ready) acc++;
            tick();
        end
        #1;
        check("bp_accepted", 64'(acc), 64'd3);
        check("bp_ready_low", 64'(if3.req_ready), 64'd0);
        check("bp_valid", 64'(if3.resp_valid), 64'd1);
        if3.req_valid = 1'b0;
        if3.resp_ready = 1'b1;
        #1;
        check("bp_ready_consume", 64'(if3.req_ready), 64'd1);
        check("bp_r0_instr", 64'(if3.resp_instr), 64'h0000_0013);
        check("bp_r0_addr", 64'(if3.resp_addr), 64'h0);
        tick();
        check("bp_r1_instr", 64'(if3.resp_instr), 64'h0000_0093);
        check("bp_r1_addr", 64'(if3.resp_addr), 64'h4);
        tick();
        check("bp_r2_instr", 64'(if3.resp_instr), 64'h0010_0113);
        check("bp_r2_addr", 64'(if3.resp_addr), 64'h8);
        tick();
        check("bp_empty", 64'(if3.resp_valid), 64'd0);

        // Lat-2 flush drops buffered and in-flight entries
        if2.resp_ready = 1'b0;
        if2.req_valid = 1'b1; if2.req_addr = 32'h10;
        tick();
        if2.req_addr = 32'h14;
        tick();
        if2.flush = 1'b1; if2.req_addr = 32'h0;
        #1;
        check("fl_ready", 64'(if2.req_ready), 64'd0);
        tick();
        if2.flush = 1'b0; if2.req_valid = 1'b0; if2.resp_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #1;
            check($sformatf("fl_quiet%0d", c), 64'(if2.resp_valid), 64'd0);
            tick();
        end
        if2.req_valid = 1'b1; if2.req_addr = 32'h0;
        #1;
        check("fl_req_ready", 64'(if2.req_ready), 64'd1);
        tick();
        if2.req_valid = 1'b0;
        check("fl_lat_gap", 64'(if2.resp_valid), 64'd0);
        tick();
        check("fl_resp_valid", 64'(if2.resp_valid), 64'd1);
        check("fl_resp_instr", 64'(if2.resp_instr), 64'h0000_0013);
        check("fl_resp_addr", 64'(if2.resp_addr), 64'h0);
        tick();
        check("fl_drain", 64'(if2.resp_valid), 64'd0);

        // Async reset with lat-3 requests in flight
        if3.resp_ready = 1'b0;
        if3.req_valid = 1'b1; if3.req_addr = 32'h10;
        tick();
        if3.req_addr = 32'h14;
        tick();
        if3.req_valid = 1'b0;
        tick();
        check("rs_pre_valid", 64'(if3.resp_valid), 64'd1);
        #2 rst = 1'b1;
        #1;
        check("rs_valid", 64'(if3.resp_valid), 64'd0);
        check("rs_instr", 64'(if3.resp_instr), 64'd0);
        check("rs_addr", 64'(if3.resp_addr), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        if3.resp_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            #1;
            check($sformatf("rs_stale%0d", c), 64'(if3.resp_valid), 64'd0);
            check($sformatf("rs_ready%0d", c), 64'(if3.req_ready), 64'd1);
            tick();
        end

        // Loaded word survives reset
        if1.req_valid = 1'b1; if1.req_addr = 32'h8; if1.resp_ready = 1'b1;
        tick();
        if1.req_valid = 1'b0;
        check("rs_mem_kept", 64'(if1.resp_instr), 64'hDEAD_BEEF);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
